fold_sig_compactor: RTL and testbench

- Sequential stage directly downstream of the 16-to-8 XOR fold netlist.
- Consumes one pair of folded 8-bit words (aa, bb) per accepted beat and compacts each stream into an 8-bit MISR signature over a frame of FRAME_LEN beats, or fewer if the frame is flushed early.
- At frame end it presents both signatures, the beat count and an equality flag on a valid/ready output, then re-arms for the next frame.

---
 rtl/fold_sig_pkg.sv | 21 ++
 rtl/fold_sig_compactor_misr.sv | 28 ++
 rtl/fold_sig_compactor.sv | 117 +++++++++++
 tb/tb_fold_sig_compactor.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fold_sig_pkg.sv
// Shared types and helpers for the folded-signature compactor.
// MISR step function and default polynomial/seed constants.
package fold_sig_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    localparam logic [7:0] DEF_POLY = 8'h1D;
    localparam logic [7:0] DEF_SEED = 8'h00;

    function automatic logic [7:0] misr8_step(
        input logic [7:0] s,
        input logic [7:0] d,
        input logic [7:0] poly
    );
        return {s[6:0], 1'b0} ^ (s[7] ? poly : 8'h00) ^ d;
    endfunction

endpackage

// File: rtl/fold_sig_compactor_misr.sv
// 8-bit MISR with seed reload and enable.
// sig_nxt exposes the post-update value for the registered compare.
module fold_misr8
    import fold_sig_pkg::*;
#(
    parameter logic [7:0] POLY = DEF_POLY,
    parameter logic [7:0] SEED = DEF_SEED
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_seed,
    input  logic       enable,
    input  logic [7:0] data,
    output logic [7:0] sig,
    output logic [7:0] sig_nxt
);

    assign sig_nxt = misr8_step(sig, data, POLY);

    always_ff @(posedge clk) begin
        if (rst || load_seed) begin
            sig <= SEED;
        end else if (enable) begin
            sig <= sig_nxt;
        end
    end

endmodule

// File: rtl/fold_sig_compactor.sv
// Frame compactor: two MISRs over folded aa/bb words, valid/ready result.
// Optional mismatch counter: define FOLD_SIG_MISMATCH_CNT_EN.
module fold_sig_compactor
    import fold_sig_pkg::*;
#(
    parameter int         FRAME_LEN = 16,
    parameter logic [7:0] POLY      = DEF_POLY,
    parameter logic [7:0] SEED      = DEF_SEED,
    parameter int         CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       aa,
    input  logic [7:0]       bb,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       sig_a,
    output logic [7:0]       sig_b,
    output logic             sig_match,
`ifdef FOLD_SIG_MISMATCH_CNT_EN
    output logic [CNT_W-1:0] mismatch_cnt,
`endif
    output logic [CNT_W-1:0] sample_cnt
);

    state_t           state_q;
    state_t           state_d;
    logic             accept;
    logic             load;
    logic [CNT_W-1:0] cnt_nxt;
    logic [7:0]       a_nxt;
    logic [7:0]       b_nxt;

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid & in_ready;
    assign cnt_nxt   = sample_cnt + 1'b1;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        unique case (state_q)
            ACCUM: begin
                if ((accept && cnt_nxt == CNT_W'(FRAME_LEN)) ||
                    (flush && (sample_cnt != '0 || accept))) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = ACCUM;
                    load    = 1'b1;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // Compare tracks the post-update signatures so it is ready with them.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            sample_cnt <= '0;
            sig_match  <= 1'b1;
        end else if (accept) begin
            sample_cnt <= cnt_nxt;
            sig_match  <= (a_nxt == b_nxt);
        end
    end

`ifdef FOLD_SIG_MISMATCH_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || load) begin
            mismatch_cnt <= '0;
        end else if (accept && aa != bb) begin
            mismatch_cnt <= mismatch_cnt + 1'b1;
        end
    end
`endif

    fold_misr8 #(
        .POLY (POLY),
        .SEED (SEED)
    ) u_misr_a (
        .clk       (clk),
        .rst       (rst),
        .load_seed (load),
        .enable    (accept),
        .data      (aa),
        .sig       (sig_a),
        .sig_nxt   (a_nxt)
    );

    fold_misr8 #(
        .POLY (POLY),
        .SEED (SEED)
    ) u_misr_b (
        .clk       (clk),
        .rst       (rst),
        .load_seed (load),
        .enable    (accept),
        .data      (bb),
        .sig       (sig_b),
        .sig_nxt   (b_nxt)
    );

endmodule

// File: tb/tb_fold_sig_compactor.sv
// Bench for fold_sig_compactor: directed frames plus random traffic
// checked against a frame-level reference model.
module tb_fold_sig_compactor;

    localparam int FL = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    aa;
    logic [7:0]    bb;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    sig_a;
    logic [7:0]    sig_b;
    logic          sig_match;
    logic [CW-1:0] sample_cnt;
`ifdef FOLD_SIG_MISMATCH_CNT_EN
    logic [CW-1:0] mismatch_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    bit        m_done;
    bit [7:0]  qa[$];
    bit [7:0]  qb[$];

    always #5 clk = ~clk;

    fold_sig_compactor #(
        .FRAME_LEN (FL),
        .POLY      (8'h1D),
        .SEED      (8'h00),
        .CNT_W     (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .aa           (aa),
        .bb           (bb),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .sig_a        (sig_a),
        .sig_b        (sig_b),
        .sig_match    (sig_match),
`ifdef FOLD_SIG_MISMATCH_CNT_EN
        .mismatch_cnt (mismatch_cnt),
`endif
        .sample_cnt   (sample_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Signature of a whole frame, folded word by word from the seed.
    function automatic logic [7:0] sig_of(input bit [7:0] q[$]);
        logic [7:0] s;
        logic [7:0] fb;
        s = 8'h00;
        foreach (q[i]) begin
            fb = s[7] ? 8'h1D : 8'h00;
            s  = ((s << 1) & 8'hFF) ^ fb ^ q[i];
        end
        return s;
    endfunction

    function automatic int diff_cnt();
        int n = 0;
        foreach (qa[i]) if (qa[i] != qb[i]) n++;
        return n;
    endfunction

    task automatic model_edge();
        if (rst) begin
            qa.delete();
            qb.delete();
            m_done = 1'b0;
        end else if (m_done) begin
            if (out_ready) begin
                qa.delete();
                qb.delete();
                m_done = 1'b0;
            end
        end else begin
            if (in_valid) begin
                qa.push_back(aa);
                qb.push_back(bb);
            end
            if ((in_valid && qa.size() == FL) ||
                (flush && qa.size() != 0))
                m_done = 1'b1;
        end
    endtask

    task automatic model_check();
        chk("in_ready", in_ready, !m_done);
        chk("out_valid", out_valid, m_done);
        if (m_done || qa.size() == 0) begin
            chk("sig_a", sig_a, sig_of(qa));
            chk("sig_b", sig_b, sig_of(qb));
            chk("sig_match", sig_match, sig_of(qa) == sig_of(qb));
            chk("sample_cnt", sample_cnt, qa.size());
`ifdef FOLD_SIG_MISMATCH_CNT_EN
            chk("mismatch_cnt", mismatch_cnt, diff_cnt());
`endif
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        model_check();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic beat(input logic [7:0] a, input logic [7:0] b,
                        input logic f);
        in_valid = 1'b1;
        aa       = a;
        bb       = b;
        flush    = f;
        cyc();
        idle();
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
    endtask

    task automatic frame_mixed();
        beat(8'h01, 8'h80, 1'b0);
        for (int i = 0; i < 3; i++) beat(8'h00, 8'h00, 1'b0);
        chk("f2_valid", out_valid, 1);
        chk("f2_sig_a", sig_a, 8'h08);
        chk("f2_sig_b", sig_b, 8'h74);
        chk("f2_match", sig_match, 0);
        chk("f2_cnt", sample_cnt, 4);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        aa        = 8'h00;
        bb        = 8'h00;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_sig_a", sig_a, 8'h00);
        chk("rst_sig_b", sig_b, 8'h00);
        chk("rst_match", sig_match, 1);

        frame_mixed();
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("bp_in_ready", in_ready, 0);
            chk("bp_sig_a", sig_a, 8'h08);
            chk("bp_sig_b", sig_b, 8'h74);
        end
        handoff();
        chk("ho_in_ready", in_ready, 1);
        beat(8'h01, 8'h01, 1'b0);
        chk("new_sig_a", sig_a, 8'h01);
        flush = 1'b1;
        cyc();
        idle();
        chk("fl1_cnt", sample_cnt, 1);
        handoff();

        for (int i = 0; i < 4; i++) beat(8'h5A, 8'h5A, 1'b0);
        chk("eq_match", sig_match, 1);
        chk("eq_cnt", sample_cnt, 4);
        handoff();

        beat(8'h01, 8'h00, 1'b0);
        beat(8'h00, 8'h00, 1'b1);
        chk("ef_valid", out_valid, 1);
        chk("ef_cnt", sample_cnt, 2);
        chk("ef_sig_a", sig_a, 8'h02);
        handoff();
        flush = 1'b1;
        cyc();
        cyc();
        idle();
        chk("ef0_valid", out_valid, 0);

        for (int i = 0; i < 3; i++) beat(8'hC3, 8'h11, 1'b0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        frame_mixed();
        handoff();

        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            aa        = 8'($urandom);
            bb        = ($urandom_range(0, 1) != 0) ? aa : 8'($urandom);
            flush     = ($urandom_range(0, 7) == 0);
            out_ready = ($urandom_range(0, 2) == 0);
            rst       = ($urandom_range(0, 199) == 0);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
